deserializador_n: RTL and testbench

DESERIALIZADOR_N -- requirements
Module: deserializador_n

---
 rtl/deserializador_n_if.sv | 24 ++
 rtl/deserializador_n.sv | 125 ++++++++++++
 tb/tb_deserializador_n.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/deserializador_n_if.sv
// rtl/deserializador_n_if.sv - serial-in / word-out handshake bundle for deserializador_n
interface deserializador_n_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                         data_in;
  logic                         write_in;
  logic                         ack_in;
  logic                         status_out;
  logic [WIDTH-1:0]             data_out;
  logic                         data_ready;
  logic [$clog2(DEPTH+1)-1:0]   fill_level;
  logic                         parity_err;

  modport master (
    output data_in, write_in, ack_in,
    input  status_out, data_out, data_ready, fill_level, parity_err
  );

  modport slave (
    input  data_in, write_in, ack_in,
    output status_out, data_out, data_ready, fill_level, parity_err
  );
endinterface

// File: rtl/deserializador_n.sv
// rtl/deserializador_n.sv - MSB-first serial-to-word deserializer with output word queue
// Optional even-parity check compiled in by DESERI_PARITY_EN.
module deserializador_n #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk_100KHz,
  input  logic              reset,
  deserializador_n_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BC_W  = $clog2(WIDTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIDTH - 1);

`ifdef DESERI_PARITY_EN
  typedef enum logic [0:0] {SHIFT = 1'b0, PAR = 1'b1} state_t;
  logic parity_err_q;
`else
  typedef enum logic [0:0] {SHIFT = 1'b0} state_t;
`endif

  state_t           state;
  logic [BC_W-1:0]  bit_cnt;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             accept;
  logic             pop;
  logic             push;
  logic [WIDTH-1:0] push_word;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign bus.status_out = (count < FULL);
  assign bus.data_ready = (count != '0);
  assign bus.data_out   = bus.data_ready ? mem[rd_ptr] : '0;
  assign bus.fill_level = count;
`ifdef DESERI_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  // A bit is taken only when the queue has room, so a push never meets a full queue.
  assign accept = bus.write_in && bus.status_out;
  assign pop    = bus.ack_in && bus.data_ready;

  always_comb begin
    push      = 1'b0;
    push_word = {shift[WIDTH-2:0], bus.data_in};
    if (accept) begin
`ifdef DESERI_PARITY_EN
      if (state == PAR) begin
        push_word = shift;
        push      = (^{shift, bus.data_in}) == 1'b0;
      end
`else
      if (state == SHIFT && bit_cnt == LAST_BIT) begin
        push = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk_100KHz) begin
    if (reset) begin
      state   <= SHIFT;
      bit_cnt <= '0;
      shift   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
`ifdef DESERI_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
`ifdef DESERI_PARITY_EN
      parity_err_q <= 1'b0;
      if (accept) begin
        case (state)
          SHIFT: begin
            shift <= push_word;
            if (bit_cnt == LAST_BIT) begin
              state   <= PAR;
              bit_cnt <= BC_W'(WIDTH);
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: begin
            state        <= SHIFT;
            bit_cnt      <= '0;
            parity_err_q <= ^{shift, bus.data_in};
          end
        endcase
      end
`else
      if (accept) begin
        shift   <= push_word;
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end
`endif
      if (push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_deserializador_n.sv
// tb/tb_deserializador_n.sv - self-checking bench for deserializador_n against a queue model
module tb_deserializador_n;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef DESERI_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  int   mq[$];
  int   m_part = 0;
  int   m_nbits = 0;
  logic m_perr = 1'b0;

  deserializador_n_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  deserializador_n #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_100KHz (clk),
    .reset      (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Inputs are applied at a falling edge, the model advances, and the call returns at the next falling edge.
  task automatic drive(input logic r, input logic w, input logic d, input logic a);
    bit acc;
    bit pp;
    rst = r; bus.write_in = w; bus.data_in = d; bus.ack_in = a;
    if (r) begin
      mq.delete(); m_part = 0; m_nbits = 0; m_perr = 1'b0;
    end else begin
      acc = w && (mq.size() < DEPTH);
      pp  = a && (mq.size() > 0);
      m_perr = 1'b0;
      if (pp) void'(mq.pop_front());
      if (acc) begin
        m_part = (m_part << 1) | int'(d);
        m_nbits++;
        if (m_nbits == NB) begin
`ifdef DESERI_PARITY_EN
          if ($countones(m_part) % 2 == 0) mq.push_back(m_part >> 1);
          else m_perr = 1'b1;
`else
          mq.push_back(m_part);
`endif
          m_part = 0; m_nbits = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  function automatic logic bit_of(input logic [WIDTH-1:0] w, input int k, input bit bad);
    if (k < WIDTH) return w[WIDTH-1-k];
    return (^w) ^ bad;
  endfunction

  task automatic send_word(input logic [WIDTH-1:0] w, input bit bad, input bit ack_last);
    for (int k = 0; k < NB; k++) drive(1'b0, 1'b1, bit_of(w, k, bad), ack_last && (k == NB - 1));
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.status_out !== 1'b1) begin n_err++; $display("FAIL reset_status: got %0b expected 1", bus.status_out); end
    n_cmp++; if (bus.data_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %0b expected 0", bus.data_ready); end
    n_cmp++; if (bus.data_out !== 8'h00) begin n_err++; $display("FAIL reset_data: got %0h expected 00", bus.data_out); end
    n_cmp++; if (bus.fill_level !== 3'd0) begin n_err++; $display("FAIL reset_fill: got %0d expected 0", bus.fill_level); end
    n_cmp++; if (bus.parity_err !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %0b expected 0", bus.parity_err); end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_a5;
    for (int k = 0; k < NB; k++) begin
      drive(1'b0, 1'b1, bit_of(8'hA5, k, 1'b0), 1'b0);
      if (k == NB - 2) begin
        n_cmp++; if (bus.data_ready !== 1'b0) begin n_err++; $display("FAIL a5_early_ready: got %0b expected 0", bus.data_ready); end
      end
    end
    n_cmp++; if (bus.data_ready !== 1'b1) begin n_err++; $display("FAIL a5_ready: got %0b expected 1", bus.data_ready); end
    n_cmp++; if (bus.data_out !== 8'hA5) begin n_err++; $display("FAIL a5_data: got %0h expected a5", bus.data_out); end
    n_cmp++; if (bus.fill_level !== 3'd1) begin n_err++; $display("FAIL a5_fill: got %0d expected 1", bus.fill_level); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.data_ready !== 1'b0) begin n_err++; $display("FAIL a5_drain: got %0b expected 0", bus.data_ready); end
  endtask

  task automatic test_full;
    for (int w = 1; w <= 5; w++) begin
      send_word(WIDTH'(w), 1'b0, 1'b0);
      if (w == 4) begin
        n_cmp++; if (bus.status_out !== 1'b0) begin n_err++; $display("FAIL full_status: got %0b expected 0", bus.status_out); end
      end
    end
    n_cmp++; if (bus.fill_level !== 3'd4) begin n_err++; $display("FAIL full_fill: got %0d expected 4", bus.fill_level); end
    for (int w = 1; w <= 4; w++) begin
      n_cmp++; if (bus.data_out !== WIDTH'(w)) begin n_err++; $display("FAIL full_pop%0d: got %0h expected %0h", w, bus.data_out, w); end
      drive(1'b0, 1'b0, 1'b0, 1'b1);
    end
    n_cmp++; if (bus.data_ready !== 1'b0) begin n_err++; $display("FAIL full_empty: got %0b expected 0", bus.data_ready); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.fill_level !== 3'd0) begin n_err++; $display("FAIL full_ack_empty: got %0d expected 0", bus.fill_level); end
  endtask

  task automatic test_simultaneous;
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    send_word(8'h33, 1'b0, 1'b0);
    n_cmp++; if (bus.fill_level !== 3'd3) begin n_err++; $display("FAIL simul_pre: got %0d expected 3", bus.fill_level); end
    send_word(8'h44, 1'b0, 1'b1);
    n_cmp++; if (bus.fill_level !== 3'd3) begin n_err++; $display("FAIL simul_fill: got %0d expected 3", bus.fill_level); end
    n_cmp++; if (bus.data_out !== 8'h22) begin n_err++; $display("FAIL simul_head: got %0h expected 22", bus.data_out); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.data_out !== 8'(mq[0])) begin n_err++; $display("FAIL simul_drain%0d: got %0h expected %0h", i, bus.data_out, mq[0]); end
      drive(1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset_midword;
    send_word(8'h77, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.fill_level !== 3'd0) begin n_err++; $display("FAIL mid_reset_fill: got %0d expected 0", bus.fill_level); end
    send_word(8'h3C, 1'b0, 1'b0);
    n_cmp++; if (bus.data_out !== 8'h3C) begin n_err++; $display("FAIL mid_reset_data: got %0h expected 3c", bus.data_out); end
    n_cmp++; if (bus.fill_level !== 3'd1) begin n_err++; $display("FAIL mid_reset_fill2: got %0d expected 1", bus.fill_level); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_gaps;
    for (int k = 0; k < NB; k++) begin
      drive(1'b0, 1'b1, bit_of(8'hF0, k, 1'b0), 1'b0);
      if (k < NB - 1) begin
        for (int g = 0; g < 3; g++) drive(1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (bus.data_ready !== 1'b0) begin n_err++; $display("FAIL gap_ready%0d: got %0b expected 0", k, bus.data_ready); end
      end
    end
    n_cmp++; if (bus.data_ready !== 1'b1) begin n_err++; $display("FAIL gap_done: got %0b expected 1", bus.data_ready); end
    n_cmp++; if (bus.data_out !== 8'hF0) begin n_err++; $display("FAIL gap_data: got %0h expected f0", bus.data_out); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

`ifdef DESERI_PARITY_EN
  task automatic test_parity;
    send_word(8'hA5, 1'b0, 1'b0);
    n_cmp++; if (bus.fill_level !== 3'd1) begin n_err++; $display("FAIL par_good_fill: got %0d expected 1", bus.fill_level); end
    n_cmp++; if (bus.parity_err !== 1'b0) begin n_err++; $display("FAIL par_good_err: got %0b expected 0", bus.parity_err); end
    send_word(8'hA5, 1'b1, 1'b0);
    n_cmp++; if (bus.parity_err !== 1'b1) begin n_err++; $display("FAIL par_bad_err: got %0b expected 1", bus.parity_err); end
    n_cmp++; if (bus.fill_level !== 3'd1) begin n_err++; $display("FAIL par_bad_fill: got %0d expected 1", bus.fill_level); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.parity_err !== 1'b0) begin n_err++; $display("FAIL par_pulse_len: got %0b expected 0", bus.parity_err); end
  endtask
`endif

  task automatic test_random;
    logic [7:0] exp_d;
    for (int c = 0; c < 1500; c++) begin
      int ack_bias = ((c / 100) % 2 == 0) ? 1 : 3;
      drive(($urandom % 250) == 0, ($urandom % 4) != 0, $urandom % 2, ($urandom % 4) < ack_bias);
      exp_d = (mq.size() > 0) ? 8'(mq[0]) : 8'h00;
      n_cmp++; if (bus.status_out !== (mq.size() < DEPTH)) begin n_err++; $display("FAIL rnd_status@%0d: got %0b expected %0b", c, bus.status_out, mq.size() < DEPTH); end
      n_cmp++; if (bus.data_ready !== (mq.size() > 0)) begin n_err++; $display("FAIL rnd_ready@%0d: got %0b expected %0b", c, bus.data_ready, mq.size() > 0); end
      n_cmp++; if (bus.data_out !== exp_d) begin n_err++; $display("FAIL rnd_data@%0d: got %0h expected %0h", c, bus.data_out, exp_d); end
      n_cmp++; if (bus.fill_level !== 3'(mq.size())) begin n_err++; $display("FAIL rnd_fill@%0d: got %0d expected %0d", c, bus.fill_level, mq.size()); end
      n_cmp++; if (bus.parity_err !== m_perr) begin n_err++; $display("FAIL rnd_perr@%0d: got %0b expected %0b", c, bus.parity_err, m_perr); end
    end
  endtask

  initial begin
    bus.data_in = 1'b0; bus.write_in = 1'b0; bus.ack_in = 1'b0;
    test_reset;
    test_a5;
    test_full;
    test_simultaneous;
    test_reset_midword;
    test_gaps;
`ifdef DESERI_PARITY_EN
    test_parity;
`endif
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
